pc_fetch_unit: RTL and testbench

- Front-end fetch stage. Sits directly upstream of the IF pipeline register.
- Owns the program counter and drives the instruction-memory/I-cache read handshake.
- Presents pc, pc+4 and the fetched instruction to the IF register, with a busywait that tells the register when the instruction is valid.
- Handles branch/jump redirects, pipeline holds, and redirects that arrive while a memory access is still outstanding.

---
 rtl/pc_fetch_unit.sv | 135 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, runs the instruction-memory read handshake and presents
// pc / pc+4 / instruction with a busywait to the IF pipeline register.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_jump_signal,
    input  logic [31:0] branch_target,
    input  logic        hold,
    input  logic        imem_busywait,
    input  logic [31:0] imem_readdata,
    output logic        imem_read,
    output logic [31:0] imem_address,
    output logic [31:0] pc_out,
    output logic [31:0] pc_4_out,
    output logic [31:0] instruction_out,
    output logic        busywait
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] ST_REQ   = 2'd0;
    localparam logic [1:0] ST_HELD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]      state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] hold_buf, hold_buf_nxt;
    logic [XLEN-1:0] redirect_pc, redirect_pc_nxt;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;
    logic            unused_target_lsbs;

    assign target             = {branch_target[XLEN-1:2], 2'b00};
    assign pc_plus4           = pc + XLEN'(4);
    assign unused_target_lsbs = ^branch_target[1:0];

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_REQ;
            pc          <= RESET_VECTOR;
            hold_buf    <= '0;
            redirect_pc <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            hold_buf    <= hold_buf_nxt;
            redirect_pc <= redirect_pc_nxt;
        end
    end

    // Next-state: redirect beats hold beats sequential advance
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        hold_buf_nxt    = hold_buf;
        redirect_pc_nxt = redirect_pc;
        case (state)
            ST_REQ: begin
                if (branch_jump_signal) begin
                    if (imem_busywait) begin
                        redirect_pc_nxt = target;
                        state_nxt       = ST_DRAIN;
                    end else begin
                        pc_nxt = target;
                    end
                end else if (!imem_busywait) begin
                    if (hold) begin
                        hold_buf_nxt = imem_readdata;
                        state_nxt    = ST_HELD;
                    end else begin
                        pc_nxt = pc_plus4;
                    end
                end
            end
            ST_HELD: begin
                if (branch_jump_signal) begin
                    pc_nxt    = target;
                    state_nxt = ST_REQ;
                end else if (!hold) begin
                    pc_nxt    = pc_plus4;
                    state_nxt = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // The in-flight access cannot be aborted; the newest target wins.
                if (branch_jump_signal) begin
                    redirect_pc_nxt = target;
                end
                if (!imem_busywait) begin
                    pc_nxt    = branch_jump_signal ? target : redirect_pc;
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_REQ;
            end
        endcase
    end

    // Handshake and presentation outputs; busywait depends only on state and imem_busywait
    always_comb begin
        imem_read       = 1'b0;
        busywait        = 1'b1;
        instruction_out = '0;
        if (reset) begin
            case (state)
                ST_REQ: begin
                    imem_read = 1'b1;
                    busywait  = imem_busywait;
                    if (!imem_busywait) begin
                        instruction_out = imem_readdata;
                    end
                end
                ST_HELD: begin
                    busywait        = 1'b0;
                    instruction_out = hold_buf;
                end
                ST_DRAIN: begin
                    imem_read = 1'b1;
                end
                default: begin
                    imem_read = 1'b0;
                end
            endcase
        end
    end

    assign imem_address = pc;
    assign pc_out       = pc;
    assign pc_4_out     = pc_plus4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a flag-level reference model checked every cycle.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        branch_jump_signal = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        hold = 1'b0;
    logic        imem_busywait = 1'b0;
    logic [31:0] imem_readdata;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] pc_out;
    logic [31:0] pc_4_out;
    logic [31:0] instruction_out;
    logic        busywait;

    int n_checks = 0;
    int n_errors = 0;

    pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk                (clk),
        .reset              (reset),
        .branch_jump_signal (branch_jump_signal),
        .branch_target      (branch_target),
        .hold               (hold),
        .imem_busywait      (imem_busywait),
        .imem_readdata      (imem_readdata),
        .imem_read          (imem_read),
        .imem_address       (imem_address),
        .pc_out             (pc_out),
        .pc_4_out           (pc_4_out),
        .instruction_out    (instruction_out),
        .busywait           (busywait)
    );

    always #5 clk = ~clk;

    // Memory image: each word is its address scrambled with a fixed key
    assign imem_readdata = imem_address ^ KEY;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the fetch unit is doing, as flags rather than states
    logic [31:0] m_pc = RV;
    logic        m_held = 1'b0;
    logic [31:0] m_word = 32'h0;
    logic        m_drain = 1'b0;
    logic [31:0] m_target = 32'h0;
    logic [31:0] tgt;

    assign tgt = branch_target & 32'hFFFF_FFFC;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc    <= RV;
            m_held  <= 1'b0;
            m_drain <= 1'b0;
        end else if (m_drain) begin
            if (branch_jump_signal) m_target <= tgt;
            if (!imem_busywait) begin
                m_pc    <= branch_jump_signal ? tgt : m_target;
                m_drain <= 1'b0;
            end
        end else if (m_held) begin
            if (branch_jump_signal) begin
                m_pc   <= tgt;
                m_held <= 1'b0;
            end else if (!hold) begin
                m_pc   <= m_pc + 32'd4;
                m_held <= 1'b0;
            end
        end else if (branch_jump_signal) begin
            if (imem_busywait) begin
                m_target <= tgt;
                m_drain  <= 1'b1;
            end else begin
                m_pc <= tgt;
            end
        end else if (!imem_busywait) begin
            if (hold) begin
                m_held <= 1'b1;
                m_word <= m_pc ^ KEY;
            end else begin
                m_pc <= m_pc + 32'd4;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("pc_out", pc_out, m_pc);
        chk("pc_4_out", pc_4_out, m_pc + 32'd4);
        chk("imem_address", imem_address, m_pc);
        if (!reset) begin
            chk("rst_imem_read", 32'(imem_read), 32'd0);
            chk("rst_busywait", 32'(busywait), 32'd1);
            chk("rst_instr", instruction_out, 32'd0);
        end else if (m_held) begin
            chk("held_imem_read", 32'(imem_read), 32'd0);
            chk("held_busywait", 32'(busywait), 32'd0);
            chk("held_instr", instruction_out, m_word);
        end else if (m_drain) begin
            chk("drain_imem_read", 32'(imem_read), 32'd1);
            chk("drain_busywait", 32'(busywait), 32'd1);
        end else begin
            chk("req_imem_read", 32'(imem_read), 32'd1);
            chk("req_busywait", 32'(busywait), 32'(imem_busywait));
            if (!imem_busywait) chk("req_instr", instruction_out, m_pc ^ KEY);
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("lit_rst_read", 32'(imem_read), 32'd0);
        chk("lit_rst_busy", 32'(busywait), 32'd1);
        chk("lit_rst_instr", instruction_out, 32'd0);
        chk("lit_rst_pc4", pc_4_out, 32'h4);
        go();
        go();
        reset = 1'b1;
        #1;
        chk("lit_first_read", 32'(imem_read), 32'd1);
        chk("lit_first_instr", instruction_out, 32'hA5A5_0000);
        go(); #1; chk("lit_pc4", pc_out, 32'h4);
        go(); #1; chk("lit_pc8", pc_out, 32'h8);

        // Three-cycle memory stall at pc=8
        imem_busywait = 1'b1;
        #1; chk("lit_stall_busy", 32'(busywait), 32'd1);
        go(); #1; chk("lit_stall_pc", pc_out, 32'h8);
        go();
        go();
        imem_busywait = 1'b0;
        #1; chk("lit_stall_done_busy", 32'(busywait), 32'd0);
        go(); #1; chk("lit_pc12", pc_out, 32'hC);

        // Hold for two cycles on the word at pc=16
        go();
        hold = 1'b1;
        #1; chk("lit_hold_instr", instruction_out, 32'hA5A5_0010);
        go(); #1; chk("lit_held_read", 32'(imem_read), 32'd0);
        go();
        hold = 1'b0;
        #1; chk("lit_held_instr", instruction_out, 32'hA5A5_0010);
        go(); #1; chk("lit_pc20", pc_out, 32'h14);

        // Redirect to 0x103 while the access at 0x40 is stalled
        repeat (11) go();
        #1; chk("lit_pc40", pc_out, 32'h40);
        imem_busywait = 1'b1;
        go();
        branch_jump_signal = 1'b1;
        branch_target = 32'h0000_0103;
        go();
        branch_jump_signal = 1'b0;
        #1; chk("lit_drain_addr", imem_address, 32'h40);
        go();
        imem_busywait = 1'b0;
        #1; chk("lit_drain_busy", 32'(busywait), 32'd1);
        go();
        #1;
        chk("lit_redirect_addr", imem_address, 32'h100);
        chk("lit_redirect_instr", instruction_out, 32'hA5A5_0100);

        // Redirect plus hold while HELD; then wrap past the top of memory
        hold = 1'b1;
        go();
        branch_jump_signal = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        go();
        branch_jump_signal = 1'b0;
        hold = 1'b0;
        #1;
        chk("lit_wrap_pc", pc_out, 32'hFFFF_FFFC);
        chk("lit_wrap_pc4", pc_4_out, 32'h0);
        chk("lit_wrap_instr", instruction_out, 32'h5A5A_FFFC);
        go(); #1; chk("lit_wrap_next", pc_out, 32'h0);

        // Redirect with data ready, then two redirects during one drain
        branch_jump_signal = 1'b1;
        branch_target = 32'h0000_0202;
        go();
        branch_jump_signal = 1'b0;
        #1; chk("lit_br_ready", pc_out, 32'h200);
        imem_busywait = 1'b1;
        branch_jump_signal = 1'b1;
        branch_target = 32'h0000_0300;
        go();
        branch_target = 32'h0000_0404;
        go();
        branch_jump_signal = 1'b0;
        imem_busywait = 1'b0;
        go();
        #1; chk("lit_last_wins", pc_out, 32'h404);

        // Asynchronous reset in the middle of a stall
        repeat (3) go();
        imem_busywait = 1'b1;
        go();
        #2;
        reset = 1'b0;
        #1;
        chk("lit_async_read", 32'(imem_read), 32'd0);
        chk("lit_async_busy", 32'(busywait), 32'd1);
        chk("lit_async_pc", pc_out, RV);
        go();
        go();
        reset = 1'b1;
        imem_busywait = 1'b0;
        #1;
        chk("lit_restart_read", 32'(imem_read), 32'd1);
        chk("lit_restart_pc", pc_out, 32'h0);
        go(); #1; chk("lit_restart_pc4", pc_out, 32'h4);
        go();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
